// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with a load/ready handshake and a bit-advance enable.
// Words stream back-to-back without an idle bit when the next load lands on the last bit.
module piso_serializer #(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] p_in,
    input  logic         load,
    output logic         ready,
    input  logic         shift_en,
    output logic         s_out,
    output logic         s_valid,
    output logic         last,
    output logic [N-1:0] Q_out
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t         state_r;
    state_t         state_nx_s;
    logic [N-1:0]   sreg_r;
    logic [N-1:0]   sreg_nx_s;
    logic [N-1:0]   sreg_shift_s;
    logic [CW-1:0]  cnt_r;
    logic [CW-1:0]  cnt_nx_s;
    logic           in_shift_s;
    logic           last_s;
    logic           out_bit_s;

    // The register always moves toward whichever end is presented on s_out.
    assign sreg_shift_s = MSB_FIRST ? {sreg_r[N-2:0], 1'b0} : {1'b0, sreg_r[N-1:1]};
    assign out_bit_s    = MSB_FIRST ? sreg_r[N-1] : sreg_r[0];

    assign in_shift_s = (state_r == ST_SHIFT);
    assign last_s     = in_shift_s && (cnt_r == CNT_LAST);

    assign s_out   = in_shift_s & out_bit_s;
    assign s_valid = in_shift_s;
    assign last    = last_s;
    assign Q_out   = sreg_r;
    // Accepting on the last consumed bit is what makes streaming gapless.
    assign ready   = (!in_shift_s) || (last_s && shift_en);

    // Next-state decode: load, shift, reload on last bit, or return to idle.
    always_comb begin
        state_nx_s = state_r;
        sreg_nx_s  = sreg_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (load) begin
                    sreg_nx_s  = p_in;
                    cnt_nx_s   = {CW{1'b0}};
                    state_nx_s = ST_SHIFT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!shift_en) begin
                    state_nx_s = ST_SHIFT;
                end else if (cnt_r != CNT_LAST) begin
                    sreg_nx_s = sreg_shift_s;
                    cnt_nx_s  = cnt_r + CW'(1);
                end else if (load) begin
                    sreg_nx_s  = p_in;
                    cnt_nx_s   = {CW{1'b0}};
                    state_nx_s = ST_SHIFT;
                end else begin
                    sreg_nx_s  = {N{1'b0}};
                    cnt_nx_s   = {CW{1'b0}};
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                sreg_nx_s  = {N{1'b0}};
                cnt_nx_s   = {CW{1'b0}};
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, shift register and bit index; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            sreg_r  <= {N{1'b0}};
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_nx_s;
            sreg_r  <= sreg_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out shift register with a load handshake and a bit-advance enable. It is the transmit-side counterpart of the team's serial-in parallel-out `shift_register`. It accepts an N-bit word, then presents it one bit per enabled clock on a serial line that feeds a SIPO `shift_register` `s_in`. Back-to-back words stream with no idle bit between frames.

## Interface
- `N`, default 4: word width; legal values N >= 2.
- `MSB_FIRST`, default 1: 1 sends bit N-1 first; 0 sends bit 0 first.

- `clk`  in  1  rising-edge clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `p_in`  in  N  parallel word to serialize; sampled on an accepted load.
- `load`  in  1  word-valid request from the producer.
- `ready`  out  1  block can accept a word this cycle; a load is accepted when `load && ready` at a rising edge.
- `shift_en`  in  1  consumer advance; the current bit is consumed at an edge where `shift_en=1` in SHIFT.
- `s_out`  out  1  current serial bit.
- `s_valid`  out  1  `s_out` carries a frame bit.
- `last`  out  1  `s_out` is bit N of the current frame.
- `Q_out`  out  N  current shift-register contents, for debug and loopback checks.

## Operation
- **State register.** Two states, IDLE and SHIFT. Other registers:
  - `sreg`, N bits.
  - `cnt`, `$clog2(N)` bits: the index of the current bit within the frame, 0..N-1.
- **Reset.** While `reset_n=0`, asynchronously:
  - state=IDLE, `sreg`=0, `cnt`=0.
  - Outputs: `ready`=1, `s_out`=0, `s_valid`=0, `last`=0, `Q_out`=0.
  - A reset asserted mid-frame aborts the frame immediately. No partial-word resume.
- **Output decode.**
  - `s_out` = `sreg[N-1]` if MSB_FIRST, else `sreg[0]`; forced to 0 in IDLE.
  - `s_valid` = (state==SHIFT).
  - `last` = (state==SHIFT && cnt==N-1).
  - `Q_out` = `sreg`.
  - `ready` = (state==IDLE) || (`last` && `shift_en`).
- **IDLE.**
  - `load=1` at an edge: `sreg`<=`p_in`, `cnt`<=0, go to SHIFT.
  - Otherwise hold.
- **SHIFT, `shift_en=0`.** Hold all state; `s_out` stays stable. `load` is ignored because `ready=0` unless the block is on the last bit with `shift_en=1`.
- **SHIFT, `shift_en=1`, `cnt<N-1`.**
  - `sreg` shifts toward the output end: left if MSB_FIRST, else right.
  - The vacated bit fills with 0.
  - `cnt`<=`cnt`+1.
- **SHIFT, `shift_en=1`, `cnt==N-1` (`last`).**
  - With `load=1`: `sreg`<=`p_in`, `cnt`<=0, stay in SHIFT. This is the gapless back-to-back case.
  - With `load=0`: `sreg`<=0, `cnt`<=0, go to IDLE.
- **Load when not ready.** A `load` while `ready=0` is not accepted. `p_in` is not sampled, and the producer must hold `load` until accepted.
- **Word-to-bit order.** A word W sent with MSB_FIRST=1 into a SIPO that shifts in at its LSB reproduces W in the SIPO after N enabled edges.

## Timing
- **Load latency.** First bit appears one cycle after the accepting edge: `s_valid`=1 and `s_out`=first bit.
- **Frame length.** Exactly N `shift_en` edges. With `shift_en` tied high, a frame occupies N cycles.
- **Streaming throughput.** Continuous `load` plus `shift_en` gives one bit per cycle with no gap between frames.
- **Return to IDLE.** `s_valid` falls on the edge that consumes the last bit when no new load is accepted.
- **Combinational paths.** `ready` depends combinationally on `shift_en`. All other outputs decode from registers only.

## Test plan
1. **Reset values.** Hold `reset_n=0` with random `p_in`/`load`/`shift_en` -> `ready`=1, `s_out`=0, `s_valid`=0, `last`=0, `Q_out`=0.
2. **MSB-first frame.** N=4, MSB_FIRST=1, `shift_en`=1; load 4'b1011 once -> `s_out` = 1,0,1,1 on the 4 cycles after the load; `last` is high only on the 4th bit; `s_valid` falls next cycle; `ready` returns to 1.
3. **LSB-first frame and back-to-back.** MSB_FIRST=0; load 4'b1011 then 4'b0110 with `load` held -> `s_out` = 1,1,0,1,0,1,1,0 with no gap; the second word is accepted on the edge where the first word's `last=1`.
4. **Stall.** `shift_en` toggling 1,0,0,1,1,0,1 during 4'b1001 (MSB first) -> `s_out` holds across stalls; bits 1,0,0,1 each consumed only on `shift_en=1`; `cnt` does not advance while stalled.
5. **Load ignored mid-frame.** Pulse `load` with `p_in`=4'b1111 while `cnt`=1 of 4'b1000 -> frame continues 1,0,0,0; 4'b1111 is not captured; it is accepted later only if `load` is still high at the last-bit edge.
6. **Reset mid-frame and loopback.** Drop `reset_n` after 2 bits of 4'b1100 -> outputs return to reset values immediately. Then connect `s_out` to a SIPO `shift_register` driven by the same clock and send 4'b1010 -> the SIPO's `Q_out` equals 4'b1010 after 4 edges.
